// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs_driver
//   Initiator side of the ap_ctrl_hs / ap_ctrl_chain block-level handshake.
//   Issues a programmed number of transactions into an HLS kernel with up to
//   DEPTH of them in flight. It measures per-transaction latency, throttles
//   ap_continue with a programmable gap, and flags protocol errors and hangs.
//
// Ports
//   clock, reset         clock; asynchronous active-low reset
//   cfg_start            one-cycle run request, honoured only in IDLE
//   cfg_num_trans        transactions in the run (latched on cfg_start)
//   cfg_cont_gap         ap_continue low cycles after each done (latched)
//   dut_ap_start/ready   issue handshake with the kernel
//   dut_ap_done/continue completion handshake with the kernel
//   busy, run_done       run in progress / one-cycle end-of-run pulse
//   issued_cnt, done_cnt per-run transaction counters
//   last_latency         latency of the most recent completion
//   max_latency          largest latency seen in the current run
//   timeout_err          sticky: no ready/done progress for TIMEOUT cycles
//   proto_err            sticky: done accepted with nothing outstanding
module ap_ctrl_hs_driver #(
  parameter int CNT_W   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_trans,
  input  logic [7:0]       cfg_cont_gap,
  output logic             dut_ap_start,
  input  logic             dut_ap_ready,
  input  logic             dut_ap_done,
  output logic             dut_ap_continue,
  output logic             busy,
  output logic             run_done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             timeout_err,
  output logic             proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           st, st_n;
  logic [CNT_W-1:0] num, cyc;
  logic [7:0]       gap, gcnt;
  logic [WW-1:0]    wd;
  logic [OW-1:0]    outst, out_n;
  logic [PW-1:0]    wp, rp;
  logic [CNT_W-1:0] mem [DEPTH];

  logic             accept_cfg, active, issue, done_hs, bypass, done_ev, spurious;
  logic             push, pop, wd_hit, start_n;
  logic [CNT_W-1:0] num_n, issued_n, done_n, lat;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    accept_cfg = (st == IDLE) && cfg_start;
    active     = (st == RUN) || (st == DRAIN);
    issue      = (st == RUN) && dut_ap_start && dut_ap_ready;
    done_hs    = active && dut_ap_done && dut_ap_continue;
    // Combinational kernel: issue and done in one cycle with nothing queued,
    // so the timestamp never enters the FIFO and latency is zero.
    bypass     = issue && done_hs && (outst == '0);
    done_ev    = done_hs && (issue || (outst != '0));
    spurious   = done_hs && !done_ev;
    push       = issue && !bypass;
    pop        = done_ev && !bypass;
    wd_hit     = active && !issue && !done_ev && (wd == WW'(TIMEOUT - 1));

    num_n    = accept_cfg ? cfg_num_trans : num;
    issued_n = accept_cfg ? '0 : issued_cnt + CNT_W'(issue);
    done_n   = accept_cfg ? '0 : done_cnt + CNT_W'(done_ev);
    out_n    = outst;
    if (accept_cfg)         out_n = '0;
    else if (push && !pop)  out_n = outst + OW'(1);
    else if (pop && !push)  out_n = outst - OW'(1);

    // Modular subtraction keeps latency correct across a counter wrap.
    lat = bypass ? '0 : cyc - mem[rp];

    st_n = st;
    unique case (st)
      IDLE:  if (cfg_start) st_n = (cfg_num_trans == '0) ? FIN : RUN;
      RUN:   if (wd_hit) st_n = FIN;
             else if (issued_n == num) st_n = DRAIN;
      DRAIN: if (wd_hit) st_n = FIN;
             else if (done_cnt == num) st_n = FIN;
      FIN:   st_n = IDLE;
    endcase

    // Evaluated on next-cycle values so a raised start is held until the
    // accepting ready (outstanding can only shrink without an issue).
    start_n = (st_n == RUN) && (issued_n < num_n) && (out_n < OW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= cyc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st              <= IDLE;
      cyc             <= '0;
      num             <= '0;
      gap             <= '0;
      gcnt            <= '0;
      wd              <= '0;
      outst           <= '0;
      wp              <= '0;
      rp              <= '0;
      dut_ap_start    <= 1'b0;
      dut_ap_continue <= 1'b0;
      busy            <= 1'b0;
      run_done        <= 1'b0;
      issued_cnt      <= '0;
      done_cnt        <= '0;
      last_latency    <= '0;
      max_latency     <= '0;
      timeout_err     <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      cyc          <= cyc + CNT_W'(1);
      st           <= st_n;
      dut_ap_start <= start_n;
      busy         <= (st_n == RUN) || (st_n == DRAIN);
      run_done     <= (st_n == FIN);
      issued_cnt   <= issued_n;
      done_cnt     <= done_n;
      outst        <= out_n;

      if (accept_cfg) begin
        num          <= cfg_num_trans;
        gap          <= cfg_cont_gap;
        last_latency <= '0;
        max_latency  <= '0;
        timeout_err  <= 1'b0;
        proto_err    <= 1'b0;
        wp           <= '0;
        rp           <= '0;
      end else begin
        if (push) wp <= nxt(wp);
        if (pop)  rp <= nxt(rp);
        if (done_ev) begin
          last_latency <= lat;
          if (lat > max_latency) max_latency <= lat;
        end
        if (spurious) proto_err   <= 1'b1;
        if (wd_hit)   timeout_err <= 1'b1;
      end

      if (!active || issue || done_ev) wd <= '0;
      else                             wd <= wd + WW'(1);

      // gcnt holds the remaining low cycles; continue re-rises on the edge
      // that ends the last of them. A spurious done does not open a gap.
      if (!((st_n == RUN) || (st_n == DRAIN))) begin
        dut_ap_continue <= 1'b0;
        gcnt            <= '0;
      end else if (done_ev && (gap != '0)) begin
        dut_ap_continue <= 1'b0;
        gcnt            <= gap;
      end else if (!dut_ap_continue) begin
        dut_ap_continue <= (gcnt <= 8'd1);
        gcnt            <= (gcnt == '0) ? '0 : gcnt - 8'd1;
      end
    end
  end

endmodule

// File: doc/ap_ctrl_hs_driver.md
Name: ap_ctrl_hs_driver

Overview:
- Initiator side of the ap_ctrl_hs/ap_ctrl_chain block-level handshake. It drives ap_start and ap_continue into an HLS kernel and consumes ap_ready and ap_done.
- Issues a programmed number of transactions, allowing up to DEPTH overlapping transactions. Measures per-transaction latency and flags protocol violations and hangs.
- Sits in the simulation harness next to the kernel, in place of the static ap_start stimulus. It gives the module/loop status monitors a repeatable, throttleable start/continue pattern.

Parameters:
- CNT_W, 32, width of transaction counters, latency values and the free-running cycle counter.
- DEPTH, 4, maximum issued-but-not-done transactions; depth of the issue-timestamp FIFO (power of two, ≥1).
- TIMEOUT, 100000, cycles without any ready/done progress while busy before the timeout error is raised.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- cfg_num_trans  in  CNT_W  number of transactions in the run; latched on accepted cfg_start.
- cfg_cont_gap  in  8  cycles ap_continue is held low after each accepted done; latched with cfg_start.
- dut_ap_start  out  1  ap_start to the kernel.
- dut_ap_ready  in  1  ap_ready from the kernel.
- dut_ap_done  in  1  ap_done from the kernel.
- dut_ap_continue  out  1  ap_continue to the kernel.
- busy  out  1  high from the cycle after an accepted cfg_start until the run finishes.
- run_done  out  1  one-cycle pulse when a run finishes, normally or by timeout.
- issued_cnt  out  CNT_W  transactions accepted (ap_start & ap_ready) in the current run.
- done_cnt  out  CNT_W  transactions completed (ap_done & ap_continue) in the current run.
- last_latency  out  CNT_W  latency of the most recent completed transaction.
- max_latency  out  CNT_W  maximum latency in the current run.
- timeout_err  out  1  sticky; cleared by next accepted cfg_start.
- proto_err  out  1  sticky; ap_done accepted with nothing outstanding; cleared by next accepted cfg_start.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; cycle counter 0. Reset asserted mid-run aborts immediately: dut_ap_start drops asynchronously, and no run_done pulse is produced.
- Cycle counter: free-running, wraps modulo 2^CNT_W. Latency is computed by modular subtraction, so it is correct across a wrap.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE, on cfg_start:
  - Latch the configuration and clear counters and errors.
  - If cfg_num_trans = 0: go to FIN.
  - Otherwise: go to RUN.
- RUN:
  - dut_ap_start = 1 while issued_cnt < num and outstanding < DEPTH; otherwise 0. It is registered, and once high it stays high until an accepting ready.
  - Issue event: dut_ap_start & dut_ap_ready. It increments issued_cnt and pushes the current cycle count into the FIFO.
  - When issued_cnt reaches num, go to DRAIN.
- Done event: dut_ap_done & dut_ap_continue, in RUN or DRAIN.
  - Pop the FIFO; latency = cycle_now − popped timestamp.
  - Update last_latency and max_latency; increment done_cnt.
- Same-cycle issue and done with an empty FIFO (combinational kernel): the timestamp bypasses the FIFO, latency = 0, and outstanding is unchanged.
- Simultaneous issue and done with a non-empty FIFO: push and pop both happen and outstanding is unchanged.
- Done event with nothing outstanding and no same-cycle issue: set proto_err; the counters and FIFO are not modified.
- DRAIN: dut_ap_start = 0. When done_cnt = num, go to FIN.
- FIN: one cycle; run_done = 1; then return to IDLE. busy is low in FIN and IDLE.
- ap_continue:
  - 1 in RUN/DRAIN except during the gap. After each done event it goes low for exactly cfg_cont_gap cycles, starting the next cycle.
  - A gap of 0 means it stays high continuously.
  - It is 0 in IDLE and FIN.
- Timeout:
  - The watchdog counter resets on any issue or done event and counts otherwise while in RUN/DRAIN.
  - On reaching TIMEOUT: set timeout_err, force dut_ap_start = 0, and go to FIN. The counters retain their values.
- cfg_start outside IDLE is ignored.

Test Plan:
- Fixed-latency kernel (ready at start+1, done 5 cycles after ready), num = 3, gap = 0 -> issued_cnt = done_cnt = 3, last_latency = max_latency = 5, one run_done pulse, no errors.
- Pipelined kernel (II = 1, latency 10), DEPTH = 4, num = 8 -> dut_ap_start deasserts while 4 are outstanding; max outstanding = 4; all 8 latencies = 10.
- Combinational kernel (ready = done = start, same cycle), num = 2 -> latency 0 each, proto_err = 0.
- gap = 3, num = 2 -> dut_ap_continue low exactly 3 cycles after the first done; the second done is accepted only when continue returns high.
- Kernel that never asserts done, TIMEOUT = 50 -> timeout_err = 1 and run_done 50 cycles after the last issue; done_cnt = 0.
- Spurious ap_done in IDLE-free RUN before any issue -> proto_err = 1, done_cnt = 0. Separately, reset low mid-RUN -> all outputs 0 next sample, no run_done pulse.
